// File: rtl/dispatch_unit.sv
// dispatch_unit: allocates a tag to each decoded instruction, renames its
// source operands against a register scoreboard and hands the result to the
// issue queue through a one-entry output register.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   decoded instruction handshake
//   instr_i               instruction word
//   rs1_i, rs2_i, rd_i    architectural register numbers
//   rs1_use, rs2_use, rd_use  field-meaningful flags
//   iq_full               issue queue back-pressure
//   enq                   enqueue strobe to the issue queue
//   iq_data, iq_rs1, iq_rs2, iq_rd, iq_id   output register contents
//   wb_valid, wb_id       completion of an in-flight tag
//   free_count            number of unallocated tags
module dispatch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int NREGS      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         instr_i,
    input  logic [4:0]                    rs1_i,
    input  logic [4:0]                    rs2_i,
    input  logic [4:0]                    rd_i,
    input  logic                          rs1_use,
    input  logic                          rs2_use,
    input  logic                          rd_use,
    input  logic                          iq_full,
    output logic                          enq,
    output logic [DATA_WIDTH-1:0]         iq_data,
    output logic [32:0]                   iq_rs1,
    output logic [32:0]                   iq_rs2,
    output logic [32:0]                   iq_rd,
    output logic [$clog2(DEPTH)-1:0]      iq_id,
    input  logic                          wb_valid,
    input  logic [$clog2(DEPTH)-1:0]      wb_id,
    output logic [$clog2(DEPTH):0]        free_count
);
    localparam int TW = $clog2(DEPTH);

    logic [DEPTH-1:0] free;
    logic [NREGS-1:0] busy;
    logic [TW-1:0]    ptag [NREGS];
    logic             out_valid;

    logic [TW-1:0]    new_tag;
    logic [32:0]      rs1_n, rs2_n, rd_n;
    logic             accept;
    logic             wb_live;

    // Operand field: {pending, zeros, producer tag, register}. A producer
    // completing this very cycle is treated as already done.
    function automatic logic [32:0] src(input logic use_f, input logic [4:0] r,
                                        input logic b, input logic [TW-1:0] t,
                                        input logic wv, input logic [TW-1:0] wi);
        logic        p;
        logic [32:0] v;
        p = use_f && (r != 5'd0) && b && !(wv && (wi == t));
        v = '0;
        v[32] = p;
        if (p) v[5 +: TW] = t;
        v[4:0] = r;
        return v;
    endfunction

    // Lowest-index free tag from the registered bitmap, so a tag returned
    // this cycle only becomes allocatable next cycle.
    always_comb begin
        new_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (free[i]) new_tag = i[TW-1:0];
    end

    always_comb begin
        free_count = '0;
        for (int i = 0; i < DEPTH; i++)
            free_count = free_count + {{TW{1'b0}}, free[i]};
    end

    always_comb begin
        rs1_n = src(rs1_use, rs1_i, busy[rs1_i], ptag[rs1_i], wb_valid, wb_id);
        rs2_n = src(rs2_use, rs2_i, busy[rs2_i], ptag[rs2_i], wb_valid, wb_id);
        rd_n  = '0;
        rd_n[32]       = rd_use && (rd_i != 5'd0);
        rd_n[5 +: TW]  = new_tag;
        rd_n[4:0]      = rd_i;
    end

    assign enq      = out_valid && !iq_full && !reset;
    assign in_ready = (!out_valid || enq) && (free_count != '0) && !reset;
    assign accept   = in_valid && in_ready;
    // Completions for an already-free tag are stale and ignored.
    assign wb_live  = wb_valid && !free[wb_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            free      <= '1;
            busy      <= '0;
            for (int r = 0; r < NREGS; r++) ptag[r] <= '0;
            out_valid <= 1'b0;
            iq_data   <= '0;
            iq_rs1    <= '0;
            iq_rs2    <= '0;
            iq_rd     <= '0;
            iq_id     <= '0;
        end else begin
            if (wb_live) begin
                free[wb_id] <= 1'b1;
                for (int r = 0; r < NREGS; r++)
                    if (busy[r] && ptag[r] == wb_id) busy[r] <= 1'b0;
            end
            if (accept) begin
                free[new_tag] <= 1'b0;
                // Placed after the wb clear so a same-register rename wins.
                if (rd_use && rd_i != 5'd0) begin
                    busy[rd_i] <= 1'b1;
                    ptag[rd_i] <= new_tag;
                end
                out_valid <= 1'b1;
                iq_data   <= instr_i;
                iq_rs1    <= rs1_n;
                iq_rs2    <= rs2_n;
                iq_rd     <= rd_n;
                iq_id     <= new_tag;
            end else if (enq) begin
                out_valid <= 1'b0;
            end else if (out_valid && wb_live) begin
                // Held entry: wake operands whose producer just completed.
                if (iq_rs1[32] && iq_rs1[5 +: TW] == wb_id) begin
                    iq_rs1[32]      <= 1'b0;
                    iq_rs1[5 +: TW] <= '0;
                end
                if (iq_rs2[32] && iq_rs2[5 +: TW] == wb_id) begin
                    iq_rs2[32]      <= 1'b0;
                    iq_rs2[5 +: TW] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: accepted instructions push their
// expected issue-queue image; a monitor pops and compares on every enq.
module tb_dispatch_unit;
    logic        clk, reset, in_valid, in_ready;
    logic [31:0] instr_i;
    logic [4:0]  rs1_i, rs2_i, rd_i;
    logic        rs1_use, rs2_use, rd_use, iq_full, enq;
    logic [31:0] iq_data;
    logic [32:0] iq_rs1, iq_rs2, iq_rd;
    logic [3:0]  iq_id, wb_id;
    logic        wb_valid;
    logic [4:0]  free_count;

    dispatch_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr_i(instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .rs1_use(rs1_use), .rs2_use(rs2_use), .rd_use(rd_use),
        .iq_full(iq_full), .enq(enq), .iq_data(iq_data), .iq_rs1(iq_rs1),
        .iq_rs2(iq_rs2), .iq_rd(iq_rd), .iq_id(iq_id), .wb_valid(wb_valid),
        .wb_id(wb_id), .free_count(free_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [32:0] rs1, rs2, rd;
        logic [3:0]  id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [32:0] mk(input logic p, input logic [3:0] t, input logic [4:0] r);
        logic [32:0] v;
        v = '0;
        v[32] = p;
        v[8:5] = t;
        v[4:0] = r;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] d, input logic [32:0] s1,
                                    input logic [32:0] s2, input logic [32:0] rd,
                                    input logic [3:0] id);
        exp_t e;
        e.data = d; e.rs1 = s1; e.rs2 = s2; e.rd = rd; e.id = id;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (enq === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_enq", 64'(enq), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("iq_data", 64'(iq_data), 64'(e.data));
                check("iq_rs1",  64'(iq_rs1),  64'(e.rs1));
                check("iq_rs2",  64'(iq_rs2),  64'(e.rs2));
                check("iq_rd",   64'(iq_rd),   64'(e.rd));
                check("iq_id",   64'(iq_id),   64'(e.id));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; wb_valid = 0; iq_full = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    // Present one instruction for one cycle; in_ready is required high.
    task automatic accept(input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic ud, input exp_t e);
        in_valid = 1; instr_i = d; rs1_i = r1; rs2_i = r2; rd_i = rd;
        rs1_use = u1; rs2_use = u2; rd_use = ud;
        @(negedge clk);
        check("in_ready_on_accept", 64'(in_ready), 64'd1);
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    initial begin
        in_valid = 0; instr_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0;
        rs1_use = 0; rs2_use = 0; rd_use = 0; iq_full = 0; wb_valid = 0; wb_id = 0;
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        check("enq_in_reset", 64'(enq), 64'd0);
        check("free_count_in_reset", 64'(free_count), 64'd16);
        @(posedge clk);
        #1 reset = 0;

        // Reset / idle state
        @(negedge clk);
        check("idle_enq", 64'(enq), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_free_count", 64'(free_count), 64'd16);
        check("idle_iq_rs1", 64'(iq_rs1), 64'd0);
        check("idle_iq_rd", 64'(iq_rd), 64'd0);
        check("idle_iq_id", 64'(iq_id), 64'd0);
        @(posedge clk); #1;

        // x3 <- x1,x2 ; x4 <- x3,x1
        accept(32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 1,
               mk_exp(32'h100, mk(0,0,1), mk(0,0,2), mk(1,0,3), 4'd0));
        accept(32'h101, 5'd3, 5'd1, 5'd4, 1, 1, 1,
               mk_exp(32'h101, mk(1,0,3), mk(0,0,1), mk(1,1,4), 4'd1));
        @(negedge clk);
        check("fc_after_two", 64'(free_count), 64'd14);
        idle(2);
        check("drain_1", 64'(exp_q.size()), 64'd0);

        // Same pair, producer tag 0 completes during the second accept
        do_reset();
        accept(32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 1,
               mk_exp(32'h100, mk(0,0,1), mk(0,0,2), mk(1,0,3), 4'd0));
        wb_valid = 1; wb_id = 4'd0;
        accept(32'h101, 5'd3, 5'd1, 5'd4, 1, 1, 1,
               mk_exp(32'h101, mk(0,0,3), mk(0,0,1), mk(1,1,4), 4'd1));
        wb_valid = 0;
        accept(32'h102, 5'd0, 5'd0, 5'd5, 0, 0, 1,
               mk_exp(32'h102, mk(0,0,0), mk(0,0,0), mk(1,0,5), 4'd0));
        @(negedge clk);
        check("fc_after_wb_reuse", 64'(free_count), 64'd14);
        idle(2);

        // Held entry woken by writeback while the issue queue is full
        do_reset();
        accept(32'h300, 5'd0, 5'd0, 5'd6, 0, 0, 1,
               mk_exp(32'h300, mk(0,0,0), mk(0,0,0), mk(1,0,6), 4'd0));
        accept(32'h301, 5'd0, 5'd0, 5'd7, 0, 0, 1,
               mk_exp(32'h301, mk(0,0,0), mk(0,0,0), mk(1,1,7), 4'd1));
        accept(32'h302, 5'd0, 5'd0, 5'd8, 0, 0, 1,
               mk_exp(32'h302, mk(0,0,0), mk(0,0,0), mk(1,2,8), 4'd2));
        accept(32'h303, 5'd8, 5'd0, 5'd9, 1, 0, 1,
               mk_exp(32'h303, mk(0,0,8), mk(0,0,0), mk(1,3,9), 4'd3));
        iq_full = 1;
        @(negedge clk);
        check("hold1_enq", 64'(enq), 64'd0);
        check("hold1_in_ready", 64'(in_ready), 64'd0);
        check("hold1_pending", 64'(iq_rs1), 64'(mk(1,2,8)));
        @(posedge clk); #1;
        wb_valid = 1; wb_id = 4'd2;
        @(negedge clk);
        check("hold2_enq", 64'(enq), 64'd0);
        check("hold2_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        wb_valid = 0;
        @(negedge clk);
        check("hold3_enq", 64'(enq), 64'd0);
        check("hold3_woken", 64'(iq_rs1[32]), 64'd0);
        @(posedge clk); #1;
        iq_full = 0;
        @(negedge clk);
        check("release_enq", 64'(enq), 64'd1);
        idle(2);

        // Exhaust all tags, then free tag 5 and reuse it
        do_reset();
        for (int i = 0; i < 16; i++)
            accept(32'h200 + i, 5'd0, 5'd0, 5'd0, 0, 0, 0,
                   mk_exp(32'h200 + i, mk(0,0,0), mk(0,0,0), mk(0,4'(i),0), 4'(i)));
        wb_valid = 1; wb_id = 4'd5;
        @(negedge clk);
        check("full_fc", 64'(free_count), 64'd0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        wb_valid = 0;
        @(negedge clk);
        check("fc_after_free5", 64'(free_count), 64'd1);
        @(posedge clk); #1;
        accept(32'h2ff, 5'd0, 5'd0, 5'd0, 0, 0, 0,
               mk_exp(32'h2ff, mk(0,0,0), mk(0,0,0), mk(0,5,0), 4'd5));
        @(negedge clk);
        check("fc_after_reuse5", 64'(free_count), 64'd0);
        idle(2);

        // rd = x0 never marks busy; reads of x0 are never pending
        do_reset();
        accept(32'h400, 5'd0, 5'd0, 5'd0, 1, 0, 1,
               mk_exp(32'h400, mk(0,0,0), mk(0,0,0), mk(0,0,0), 4'd0));
        @(negedge clk);
        check("fc_rd_x0", 64'(free_count), 64'd15);
        @(posedge clk); #1;
        accept(32'h401, 5'd0, 5'd0, 5'd0, 1, 1, 0,
               mk_exp(32'h401, mk(0,0,0), mk(0,0,0), mk(0,1,0), 4'd1));
        idle(3);
        check("drain_final", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
